// File: rtl/sm83_pkg.sv
// Shared encodings for the SM83 register file: byte/pair indices, IDU ops, F mask default.
package sm83_pkg;
   localparam logic [2:0] REG_B = 3'd0;
   localparam logic [2:0] REG_C = 3'd1;
   localparam logic [2:0] REG_D = 3'd2;
   localparam logic [2:0] REG_E = 3'd3;
   localparam logic [2:0] REG_H = 3'd4;
   localparam logic [2:0] REG_L = 3'd5;
   localparam logic [2:0] REG_A = 3'd6;
   localparam logic [2:0] REG_F = 3'd7;

   localparam logic [2:0] PAIR_BC = 3'd0;
   localparam logic [2:0] PAIR_DE = 3'd1;
   localparam logic [2:0] PAIR_HL = 3'd2;
   localparam logic [2:0] PAIR_AF = 3'd3;
   localparam logic [2:0] PAIR_SP = 3'd4;
   localparam logic [2:0] PAIR_PC = 3'd5;

   localparam logic [1:0] IDU_NONE = 2'b00;
   localparam logic [1:0] IDU_INC  = 2'b01;
   localparam logic [1:0] IDU_DEC  = 2'b10;
   localparam logic [1:0] IDU_RSV  = 2'b11;

   localparam logic [7:0] F_MASK_DEF = 8'hF0;
endpackage

// File: rtl/sm83_idu.sv
// Combinational +/-1 unit for 16-bit pairs; wrap flags FFFF->0000 and 0000->FFFF.
module sm83_idu
   import sm83_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] val_i,
   input  logic [1:0]   op_i,
   output logic [W-1:0] res_o,
   output logic         wrap_o
);
   always_comb begin
      res_o  = val_i;
      wrap_o = 1'b0;
      case (op_i)
         IDU_INC: begin
            res_o  = val_i + W'(1);
            wrap_o = &val_i;
         end
         IDU_DEC: begin
            res_o  = val_i - W'(1);
            wrap_o = ~|val_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/sm83_regfile_v2.sv
// SM83 register file with muxed byte/pair reads, pair writes and integrated IDU.
// Optional SM83_REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module sm83_regfile_v2
   import sm83_pkg::*;
#(
   parameter int                    DATA_W = 8,
   parameter int                    NUM_RD = 2,
   parameter logic [DATA_W-1:0]     F_MASK = F_MASK_DEF,
   parameter logic [2*DATA_W-1:0]   SP_RST = 16'hFFFE,
   parameter logic [2*DATA_W-1:0]   PC_RST = 16'h0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*3-1:0]        rd_sel,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       wr_en,
   input  logic [2:0]                 wr_sel,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [2:0]                 pair_sel,
   output logic [2*DATA_W-1:0]        pair_rd_data,
   input  logic                       pair_wr_en,
   input  logic [2*DATA_W-1:0]        pair_wr_data,
   input  logic [1:0]                 idu_op,
   input  logic [2:0]                 idu_sel,
   output logic [2*DATA_W-1:0]        idu_addr,
   output logic                       idu_wrap,
   output logic [2*DATA_W-1:0]        pc,
   output logic [2*DATA_W-1:0]        sp
);
   localparam int PW = 2 * DATA_W;
   typedef logic [7:0][DATA_W-1:0] regs_t;

   regs_t         regs_q, regs_d, rd_regs;
   logic [PW-1:0] sp_q, sp_d, pc_q, pc_d, rd_sp, rd_pc;
   logic          wrap_q, wrap_d;
   logic          idu_act, idu_wrap_c;
   logic [PW-1:0] idu_res;

   function automatic logic [DATA_W-1:0] byte_view(input logic [2:0] sel, input regs_t r);
      return (sel == REG_F) ? (r[sel] & F_MASK) : r[sel];
   endfunction

   function automatic logic [PW-1:0] pair_view(input logic [2:0] sel, input regs_t r,
                                               input logic [PW-1:0] s, input logic [PW-1:0] p);
      case (sel)
         PAIR_BC, PAIR_DE, PAIR_HL: return {r[{sel[1:0], 1'b0}], r[{sel[1:0], 1'b1}]};
         PAIR_AF: return {r[REG_A], r[REG_F] & F_MASK};
         PAIR_SP: return s;
         PAIR_PC: return p;
         default: return '0;
      endcase
   endfunction

   // A pair write to the IDU target suppresses the IDU op (and its wrap) entirely.
   assign idu_act = ((idu_op == IDU_INC) || (idu_op == IDU_DEC)) && (idu_sel <= PAIR_PC) &&
                    !(pair_wr_en && (pair_sel == idu_sel));
   assign idu_addr = pair_view(idu_sel, regs_q, sp_q, pc_q);

   sm83_idu #(.W(PW)) u_idu (
      .val_i  (idu_addr),
      .op_i   (idu_act ? idu_op : IDU_NONE),
      .res_o  (idu_res),
      .wrap_o (idu_wrap_c)
   );

   // Later assignments override earlier ones: byte write < IDU < pair write.
   always_comb begin
      regs_d = regs_q;
      sp_d   = sp_q;
      pc_d   = pc_q;
      if (wr_en) regs_d[wr_sel] = wr_data;
      if (idu_act) begin
         case (idu_sel)
            PAIR_BC, PAIR_DE, PAIR_HL, PAIR_AF: begin
               regs_d[{idu_sel[1:0], 1'b0}] = idu_res[PW-1:DATA_W];
               regs_d[{idu_sel[1:0], 1'b1}] = idu_res[DATA_W-1:0];
            end
            PAIR_SP: sp_d = idu_res;
            PAIR_PC: pc_d = idu_res;
            default: ;
         endcase
      end
      if (pair_wr_en) begin
         case (pair_sel)
            PAIR_BC, PAIR_DE, PAIR_HL, PAIR_AF: begin
               regs_d[{pair_sel[1:0], 1'b0}] = pair_wr_data[PW-1:DATA_W];
               regs_d[{pair_sel[1:0], 1'b1}] = pair_wr_data[DATA_W-1:0];
            end
            PAIR_SP: sp_d = pair_wr_data;
            PAIR_PC: pc_d = pair_wr_data;
            default: ;
         endcase
      end
      regs_d[REG_F] = regs_d[REG_F] & F_MASK;
      wrap_d = idu_act & idu_wrap_c;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '0;
         sp_q   <= SP_RST;
         pc_q   <= PC_RST;
         wrap_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         sp_q   <= sp_d;
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

`ifdef SM83_REGFILE_BYPASS_EN
   // Forwarded view is reset-aware so a held reset never leaks pending writes.
   assign rd_regs = rst ? regs_d : '0;
   assign rd_sp   = rst ? sp_d : SP_RST;
   assign rd_pc   = rst ? pc_d : PC_RST;
`else
   assign rd_regs = regs_q;
   assign rd_sp   = sp_q;
   assign rd_pc   = pc_q;
`endif

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++)
         rd_data[i*DATA_W +: DATA_W] = byte_view(rd_sel[i*3 +: 3], rd_regs);
   end

   assign pair_rd_data = pair_view(pair_sel, rd_regs, rd_sp, rd_pc);
   assign idu_wrap     = wrap_q;
   assign pc           = pc_q;
   assign sp           = sp_q;
endmodule

// File: tb/tb_sm83_regfile_v2.sv
// Directed, table-driven bench for sm83_regfile_v2 (default and SM83_REGFILE_BYPASS_EN builds).
module tb_sm83_regfile_v2;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  rd_sel;
   logic [15:0] rd_data;
   logic        wr_en;
   logic [2:0]  wr_sel;
   logic [7:0]  wr_data;
   logic [2:0]  pair_sel;
   logic [15:0] pair_rd_data;
   logic        pair_wr_en;
   logic [15:0] pair_wr_data;
   logic [1:0]  idu_op;
   logic [2:0]  idu_sel;
   logic [15:0] idu_addr;
   logic        idu_wrap;
   logic [15:0] pc, sp;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sm83_regfile_v2 dut (
      .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .pair_sel(pair_sel), .pair_rd_data(pair_rd_data),
      .pair_wr_en(pair_wr_en), .pair_wr_data(pair_wr_data),
      .idu_op(idu_op), .idu_sel(idu_sel), .idu_addr(idu_addr), .idu_wrap(idu_wrap),
      .pc(pc), .sp(sp)
   );

   typedef struct {
      logic        we;   logic [2:0] ws;  logic [7:0]  wd;
      logic        pwe;  logic [2:0] ps;  logic [15:0] pwd;
      logic [1:0]  iop;  logic [2:0] is;
      logic [2:0]  c0;   logic [2:0] c1;  logic [2:0]  cp;
      logic [7:0]  e0;   logic [7:0] e1;  logic [15:0] ep;
      logic [15:0] epc;  logic [15:0] esp; logic       ewrap;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; pair_wr_en = 1'b0; idu_op = 2'b00;
   endtask

   initial begin
      rst = 1'b0; rd_sel = '0; wr_sel = '0; wr_data = '0; pair_sel = '0;
      pair_wr_data = '0; idu_sel = '0;
      idle();
      //              we ws  wd     pwe ps  pwd       iop    is   c0 c1 cp  e0     e1     ep        epc       esp       wrap
      vecs[0]  = '{1, 3'd6, 8'h3F, 0, 3'd0, 16'h0000, 2'b00, 3'd0, 6, 0, 3, 8'h3F, 8'h00, 16'h3F00, 16'h0000, 16'hFFFE, 0};
      vecs[1]  = '{1, 3'd7, 8'hFF, 0, 3'd0, 16'h0000, 2'b00, 3'd0, 7, 6, 3, 8'hF0, 8'h3F, 16'h3FF0, 16'h0000, 16'hFFFE, 0};
      vecs[2]  = '{0, 3'd0, 8'h00, 1, 3'd2, 16'hBEEF, 2'b00, 3'd0, 4, 5, 2, 8'hBE, 8'hEF, 16'hBEEF, 16'h0000, 16'hFFFE, 0};
      vecs[3]  = '{0, 3'd0, 8'h00, 1, 3'd5, 16'hFFFF, 2'b00, 3'd0, 0, 1, 5, 8'h00, 8'h00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0};
      vecs[4]  = '{0, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 2'b01, 3'd5, 4, 5, 5, 8'hBE, 8'hEF, 16'h0000, 16'h0000, 16'hFFFE, 1};
      vecs[5]  = '{0, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 2'b00, 3'd0, 0, 1, 4, 8'h00, 8'h00, 16'hFFFE, 16'h0000, 16'hFFFE, 0};
      vecs[6]  = '{0, 3'd0, 8'h00, 1, 3'd4, 16'h0000, 2'b00, 3'd0, 0, 1, 4, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0};
      vecs[7]  = '{0, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 2'b10, 3'd4, 0, 1, 4, 8'h00, 8'h00, 16'hFFFF, 16'h0000, 16'hFFFF, 1};
      vecs[8]  = '{0, 3'd0, 8'h00, 1, 3'd2, 16'hFFFF, 2'b00, 3'd0, 4, 5, 2, 8'hFF, 8'hFF, 16'hFFFF, 16'h0000, 16'hFFFF, 0};
      vecs[9]  = '{0, 3'd0, 8'h00, 1, 3'd2, 16'h1234, 2'b01, 3'd2, 4, 5, 2, 8'h12, 8'h34, 16'h1234, 16'h0000, 16'hFFFF, 0};
      vecs[10] = '{0, 3'd0, 8'h00, 1, 3'd2, 16'h00FF, 2'b00, 3'd0, 4, 5, 2, 8'h00, 8'hFF, 16'h00FF, 16'h0000, 16'hFFFF, 0};
      vecs[11] = '{1, 3'd5, 8'h55, 0, 3'd0, 16'h0000, 2'b01, 3'd2, 4, 5, 2, 8'h01, 8'h00, 16'h0100, 16'h0000, 16'hFFFF, 0};
      vecs[12] = '{0, 3'd0, 8'h00, 1, 3'd3, 16'h12FF, 2'b00, 3'd0, 6, 7, 3, 8'h12, 8'hF0, 16'h12F0, 16'h0000, 16'hFFFF, 0};
      vecs[13] = '{0, 3'd0, 8'h00, 1, 3'd6, 16'h5555, 2'b01, 3'd7, 0, 4, 6, 8'h00, 8'h01, 16'h0000, 16'h0000, 16'hFFFF, 0};
      vecs[14] = '{1, 3'd0, 8'h11, 1, 3'd1, 16'h2233, 2'b01, 3'd5, 0, 2, 1, 8'h11, 8'h22, 16'h2233, 16'h0001, 16'hFFFF, 0};
      vecs[15] = '{1, 3'd1, 8'h77, 0, 3'd0, 16'h0000, 2'b11, 3'd5, 1, 3, 5, 8'h77, 8'h33, 16'h0001, 16'h0001, 16'hFFFF, 0};

      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rd_sel = {3'd7, 3'd0}; pair_sel = 3'd4;
      #1;
      check("rst_B", rd_data[7:0], 8'h00);
      check("rst_F", rd_data[15:8], 8'h00);
      check("rst_pairSP", pair_rd_data, 16'hFFFE);
      check("rst_pc", pc, 16'h0000);
      check("rst_sp", sp, 16'hFFFE);
      check("rst_wrap", idu_wrap, 1'b0);
      pair_sel = 3'd3; #1;
      check("rst_pairAF", pair_rd_data, 16'h0000);

      for (int i = 0; i < 16; i++) begin
         wr_en = vecs[i].we; wr_sel = vecs[i].ws; wr_data = vecs[i].wd;
         pair_wr_en = vecs[i].pwe; pair_sel = vecs[i].ps; pair_wr_data = vecs[i].pwd;
         idu_op = vecs[i].iop; idu_sel = vecs[i].is;
         @(posedge clk); #1;
         idle();
         rd_sel = {vecs[i].c1, vecs[i].c0}; pair_sel = vecs[i].cp;
         #1;
         check($sformatf("v%0d_rd0", i), rd_data[7:0], vecs[i].e0);
         check($sformatf("v%0d_rd1", i), rd_data[15:8], vecs[i].e1);
         check($sformatf("v%0d_pair", i), pair_rd_data, vecs[i].ep);
         check($sformatf("v%0d_pc", i), pc, vecs[i].epc);
         check($sformatf("v%0d_sp", i), sp, vecs[i].esp);
         check($sformatf("v%0d_wrap", i), idu_wrap, vecs[i].ewrap);
      end

      // idu_addr is the pre-op value and masks F when reading AF
      idu_sel = 3'd2; #1;
      check("iaddr_HL", idu_addr, 16'h0100);
      idu_sel = 3'd3; #1;
      check("iaddr_AF", idu_addr, 16'h12F0);
      idu_sel = 3'd5; idu_op = 2'b01; #1;
      check("iaddr_PC_pre", idu_addr, 16'h0001);

      // back-to-back PC increments from 0000
      idle();
      pair_sel = 3'd5; pair_wr_en = 1'b1; pair_wr_data = 16'h0000;
      @(posedge clk); #1;
      pair_wr_en = 1'b0; idu_op = 2'b01; idu_sel = 3'd5;
      @(posedge clk); #1;
      check("b2b_pc1", pc, 16'h0001);
      @(posedge clk); #1;
      idle();
      check("b2b_pc2", pc, 16'h0002);
      check("b2b_wrap", idu_wrap, 1'b0);

      // same-cycle write/read of B (currently 11)
      rd_sel = {3'd1, 3'd0};
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h7A;
      #1;
`ifdef SM83_REGFILE_BYPASS_EN
      check("byp_B_same", rd_data[7:0], 8'h7A);
`else
      check("byp_B_same", rd_data[7:0], 8'h11);
`endif
      @(posedge clk); #1;
      idle(); #1;
      check("byp_B_next", rd_data[7:0], 8'h7A);

      // reset overrides every pending update at the same edge
      rst = 1'b0;
      wr_en = 1'b1; wr_sel = 3'd6; wr_data = 8'h99;
      pair_wr_en = 1'b1; pair_sel = 3'd2; pair_wr_data = 16'hCAFE;
      idu_op = 2'b01; idu_sel = 3'd5;
      @(posedge clk); #1;
      rd_sel = {3'd0, 3'd6};
      #1;
      check("mrst_A", rd_data[7:0], 8'h00);
      check("mrst_B", rd_data[15:8], 8'h00);
      check("mrst_HL", pair_rd_data, 16'h0000);
      check("mrst_pc", pc, 16'h0000);
      check("mrst_sp", sp, 16'hFFFE);
      check("mrst_wrap", idu_wrap, 1'b0);
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_HL", pair_rd_data, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sm83_regfile_v2.md
# sm83_regfile_v2

Parametrised successor register file for the SM83 core datapath. It holds the 8-bit registers B, C, D, E, H, L, A and F, plus the 16-bit SP and PC. Reads go through muxed read ports instead of the tristate `*_wrz` scheme, so there are no internal bidirectional nets. It adds 16-bit pair read/write and an integrated increment/decrement unit (IDU) for PC++, SP±, and HL+/HL- addressing. It sits between the control sequencer and the ALU/address bus.

## Interface
Parameters:
- `DATA_W`, 8: byte register width; pairs are `2*DATA_W`.
- `NUM_RD`, 2: number of independent byte read ports.
- `F_MASK`, 8'hF0: bits of F that are storable; masked bits always read 0.
- `SP_RST`, 16'hFFFE: SP reset value.
- `PC_RST`, 16'h0000: PC reset value.

Ports (clock and reset first; one clock, reset synchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `rd_sel`  in  `NUM_RD*3`  byte read selects: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 A, 7 F.
- `rd_data`  out  `NUM_RD*DATA_W`  byte read data; combinational.
- `wr_en`  in  1  byte write strobe.
- `wr_sel`  in  3  byte write target (same encoding as `rd_sel`).
- `wr_data`  in  `DATA_W`  byte write data.
- `pair_sel`  in  3  pair index: 0 BC, 1 DE, 2 HL, 3 AF, 4 SP, 5 PC; 6–7 reserved.
- `pair_rd_data`  out  `2*DATA_W`  pair read data; combinational.
- `pair_wr_en`  in  1  pair write strobe, target `pair_sel`.
- `pair_wr_data`  in  `2*DATA_W`  pair write data; high byte is the first-named register.
- `idu_op`  in  2  00 none, 01 increment, 10 decrement, 11 reserved (treated as none).
- `idu_sel`  in  3  IDU target pair (same encoding as `pair_sel`).
- `idu_addr`  out  `2*DATA_W`  pre-operation value of `idu_sel` pair; combinational.
- `idu_wrap`  out  1  registered; 1 for one cycle after an IDU op wrapped (FFFF→0000 or 0000→FFFF).
- `pc`, `sp`  out  16 each  direct register views.

## Operation
- Reset (`rst`=0 at edge): B..L, A and F become 0, SP becomes `SP_RST`, PC becomes `PC_RST`, `idu_wrap` becomes 0. During reset, `rd_data` and `pair_rd_data` reflect these values.
- F write: stored value is `data & F_MASK`. Every read of F, AF or `idu_addr` for AF is masked.
- Byte write: `wr_data` is written to `wr_sel` at the edge.
- Pair write: both bytes of `pair_sel` are written at the edge. For SP and PC the full 16 bits are written.
- IDU: `idu_addr` drives the current pair value combinationally. At the edge the pair becomes value±1, modulo 2^16.
- Reserved pair codes:
  - reads return 0;
  - writes are ignored;
  - an IDU op on a reserved code is ignored and `idu_wrap` stays 0.
- Simultaneous-event priority, applied per byte lane: reset > pair write > IDU > byte write.
  - Pair write and IDU on the same pair: pair write wins, IDU is dropped, `idu_wrap` = 0.
  - IDU and byte write on the same byte: the IDU result wins for the whole pair.
  - Non-overlapping targets all update in the same cycle.
- Reads and writes to the same register in the same cycle: reads return the old value, unless bypass is compiled in (see Configuration).

## Timing
- Read latency: 0 cycles (combinational from registers).
- Write latency: 1 edge; the new value is visible on reads in the following cycle.
- IDU: one op per cycle, back-to-back allowed. Two consecutive increments of PC from 0x0000 give 0x0002 after two edges.
- `idu_wrap` is valid for exactly the cycle after the wrapping edge.
- Reset asserted mid-sequence overrides every pending write at that edge. No partial update survives.

## Configuration
- `SM83_REGFILE_BYPASS_EN` defined:
  - Byte and pair read ports forward same-cycle write data (byte write, pair write, or IDU result, by the priority above) when the addresses match.
  - `idu_addr` is never forwarded.
- Not defined: reads always return the registered value.

## Structure
- Shared package `sm83_pkg`: byte register index constants (`REG_B`..`REG_F`), pair index constants (`PAIR_BC`..`PAIR_PC`), IDU op encodings, `F_MASK` default.
- One sub-module, `sm83_idu`: 16-bit ±1 combinational unit with a wrap output. The wrap is registered in the parent.

## Test plan
- Reset: drive `rst`=0 for 1 edge → B..L,A,F = 00, SP = FFFE, PC = 0000, `idu_wrap` = 0.
- Byte write/read: write A = 3F, then read port 0 sel 6 → 3F next cycle; write F = FF → reads F0.
- Pair write: HL ← BEEF → H = BE, L = EF, `pair_rd_data` = BEEF.
- IDU wrap: PC = FFFF, `idu_op` inc on PC → PC = 0000, `idu_wrap` = 1 for one cycle. SP = 0000 dec → FFFF, `idu_wrap` = 1.
- Conflicts:
  - `pair_wr_en` HL ← 1234 with IDU inc on HL in the same cycle → HL = 1234, `idu_wrap` = 0.
  - IDU inc HL=00FF with a byte write L=55 in the same cycle → HL = 0100.
- Bypass (macro on): write B = 7A with `rd_sel` = B in the same cycle → `rd_data` = 7A combinationally. Macro off → old value.
